// File: rtl/nisc_pkg.sv
// Shared types for the NISC datapath: sequencer states and next-pc source selects.
package nisc_pkg;

    localparam int DEFAULT_PC_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        SRC_INC    = 2'd0,
        SRC_TARGET = 2'd1,
        SRC_POP    = 2'd2,
        SRC_HOLD   = 2'd3
    } pc_src_t;

endpackage

// File: rtl/ret_stack.sv
// Small LIFO of return addresses; entry 0 is always the top of stack.
module ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem      [DEPTH];
    logic [W-1:0]  w_mem_next [DEPTH];
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_top     = r_mem[0];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !o_full && !i_pop;

    // Push shifts every entry one slot deeper, pop shifts them one slot up.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_top
                assign w_mem_next[gi] = w_do_push ? i_data : r_mem[gi+1];
            end else if (gi == DEPTH - 1) begin : g_bottom
                assign w_mem_next[gi] = w_do_push ? r_mem[gi-1] : '0;
            end else begin : g_mid
                assign w_mem_next[gi] = w_do_push ? r_mem[gi-1] : r_mem[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
            r_mem   <= w_mem_next;
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
            r_mem   <= w_mem_next;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: picks the next fetch address, owns the return stack
// error flag and raises a one-cycle flush after every redirect.
module pc_sequencer
    import nisc_pkg::*;
#(
    parameter int PC_W        = DEFAULT_PC_W,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            br_en,
    input  logic            br_inv,
    input  logic            cmp_result,
    input  logic            jmp,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            halted,
    output logic            stack_err
);
    seq_state_t      r_state;
    seq_state_t      w_state_next;
    pc_src_t         w_src;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_stack_top;
    logic            r_stack_err;
    logic            w_err_set;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_taken;

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_taken  = br_en && (cmp_result ^ br_inv);

    ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stack_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RUN;
            r_pc        <= PC_W'(RESET_PC);
            r_stack_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_err_set) r_stack_err <= 1'b1;
        end
    end

    // Defaults hold everything, which is exactly the stall behaviour.
    always_comb begin
        w_state_next = r_state;
        w_src        = SRC_HOLD;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_err_set    = 1'b0;
        if (!stall) begin
            case (r_state)
                RUN: begin
                    if (halt) begin
                        w_state_next = HALT;
                    end else if (ret && !w_empty) begin
                        w_src        = SRC_POP;
                        w_pop        = 1'b1;
                        w_state_next = FLUSH;
                    end else if (ret) begin
                        w_err_set = 1'b1;
                        w_src     = SRC_INC;
                    end else if (call) begin
                        w_push       = !w_full;
                        w_err_set    = w_full;
                        w_src        = SRC_TARGET;
                        w_state_next = FLUSH;
                    end else if (jmp || w_taken) begin
                        w_src        = SRC_TARGET;
                        w_state_next = FLUSH;
                    end else begin
                        w_src = SRC_INC;
                    end
                end
                FLUSH: begin
                    if (halt) begin
                        w_state_next = HALT;
                    end else begin
                        w_src        = SRC_INC;
                        w_state_next = RUN;
                    end
                end
                HALT: begin
                    if (resume) w_state_next = RUN;
                end
                default: w_state_next = RUN;
            endcase
        end

        case (w_src)
            SRC_INC:    w_pc_next = w_pc_inc;
            SRC_TARGET: w_pc_next = target;
            SRC_POP:    w_pc_next = w_stack_top;
            default:    w_pc_next = r_pc;
        endcase
    end

    always_comb begin
        flush  = (r_state == FLUSH);
        halted = (r_state == HALT);
    end

    assign pc        = r_pc;
    assign stack_err = r_stack_err;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the NISC datapath. It sits directly downstream of the single-bit branch comparator and consumes its equality result.
- Each cycle it picks the next PC from these sources: sequential increment, conditional branch, jump, call, or return.
- It holds a small hardware return stack.
- After any redirect it raises a one-cycle flush so decode squashes the wrongly fetched instruction. It also supports halt/resume.

Parameters:
- PC_W, 8, program counter width in bits; address space 2^PC_W words.
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freezes pc, state, stack and outputs while high.
- halt  input  1  request to stop fetching.
- resume  input  1  leave HALT.
- br_en  input  1  current instruction is a conditional branch.
- br_inv  input  1  branch taken on mismatch instead of match.
- cmp_result  input  1  equality bit from the branch comparator (1 = operands equal).
- jmp  input  1  unconditional jump.
- call  input  1  push return address, then jump.
- ret  input  1  pop return address into pc.
- target  input  PC_W  branch/jump/call destination.
- pc  output  PC_W  current fetch address.
- flush  output  1  squash the instruction in decode.
- halted  output  1  high while in HALT.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset; it is the only reset.
- Reset values: pc = RESET_PC, state = RUN, flush = 0, halted = 0, stack empty (count 0), stack_err = 0.
- Reset priority: reset wins over every other input in every state, including mid-FLUSH and during HALT.
- States: RUN, FLUSH, HALT. flush is a registered output, 1 exactly when state = FLUSH. halted is 1 exactly when state = HALT.
- stall = 1 in any state: nothing changes. All control inputs are ignored that cycle.
- RUN, with stall = 0, takes the first matching action in this priority order:
  1. halt: pc holds, next state HALT.
  2. ret with stack not empty: pc ← top entry, pop, next state FLUSH.
  3. ret with stack empty: stack_err ← 1, pc ← pc+1, stay RUN, no flush.
  4. call with stack not full: push pc+1, pc ← target, next state FLUSH.
  5. call with stack full: stack_err ← 1, push dropped, pc ← target, next state FLUSH.
  6. jmp: pc ← target, next state FLUSH.
  7. br_en with taken = cmp_result XOR br_inv equal to 1: pc ← target, next state FLUSH.
  8. Otherwise, including a branch that is not taken: pc ← pc+1, stay RUN.
- FLUSH, with stall = 0: pc ← pc+1. All control inputs except halt are ignored, since they belong to the squashed instruction. Next state RUN.
- HALT:
  - pc holds.
  - resume = 1 → next state RUN; the first fetch is the held pc.
  - halt and resume both high → resume wins.
  - All other control inputs are ignored.
- Arithmetic: pc+1 and pushed addresses wrap modulo 2^PC_W (all-ones + 1 = 0). No carry-out.
- Stack:
  - LIFO, with a count register from 0 to STACK_DEPTH.
  - Full means count = STACK_DEPTH; empty means count = 0.
  - stack_err clears only on reset.
- Latency: a redirect decided in cycle N appears on pc in cycle N+1, and flush is high in cycle N+1.

Decomposition:
- Shared package nisc_pkg:
  - seq_state_t enum {RUN, FLUSH, HALT}.
  - PC_W default constant.
  - next-pc source enum {SRC_INC, SRC_TARGET, SRC_POP, SRC_HOLD}.
- One sub-module, ret_stack: push/pop/top/full/empty, parameterised on width and depth, no error logic. pc_sequencer owns the error flag and the priority logic.

Test Plan:
- Reset then 5 idle cycles, PC_W = 8 → pc = 0,1,2,3,4,5; flush = 0 throughout.
- At pc = 0x10: br_en = 1, cmp_result = 1, br_inv = 0, target = 0x40 → next cycle pc = 0x40, flush = 1; following cycle pc = 0x41, flush = 0. Repeat with cmp_result = 0 → pc = 0x11, no flush. Repeat with br_inv = 1 and cmp_result = 0 → taken.
- call at pc = 0x05, target 0x80; run to 0x83; ret → pc = 0x06 with one flush cycle. Five nested calls with STACK_DEPTH = 4 → stack_err = 1, fifth jump still taken. ret on empty stack → stack_err stays 1, pc increments.
- pc = 0xFF, idle → pc = 0x00. stall held 3 cycles at pc = 0x20 during FLUSH → pc and flush frozen, then resume normal sequence.
- halt at pc = 0x30 → halted = 1, pc = 0x30 for 4 cycles with jmp toggling ignored; resume → pc = 0x30 then 0x31. reset asserted during FLUSH → pc = RESET_PC and flush = 0 the next cycle.
